pipeline_hazard_ctrl: RTL and testbench

Central sequencer for the 5-stage pipeline. It drives the enable and flush inputs of the IF_ID, ID_EX, EX_MEM and MEM_WB registers and the PC write enable. It resolves load-use hazards, ID-stage branch mispredicts, instruction-memory and data-memory wait handshakes, and the HLT drain. It also keeps a saturating stall counter and flags a sticky data-memory timeout error.

---
 rtl/pipeline_hazard_ctrl_pkg.sv | 33 +++
 rtl/pipeline_hazard_ctrl_if.sv | 45 ++++
 rtl/pipeline_hazard_ctrl_hazard_detect.sv | 22 ++
 rtl/pipeline_hazard_ctrl.sv | 136 +++++++++++++
 tb/tb_pipeline_hazard_ctrl.sv | 352 +++++++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the pipeline sequencer: FSM state codes, register
// index helpers and the packed bundle of stage enables/flushes.
package pipe_ctrl_pkg;

    localparam logic [1:0] ST_RUN    = 2'd0;
    localparam logic [1:0] ST_DWAIT  = 2'd1;
    localparam logic [1:0] ST_DRAIN  = 2'd2;
    localparam logic [1:0] ST_HALTED = 2'd3;

    localparam int         REG_W    = 4;
    localparam logic [3:0] REG_ZERO = 4'd0;

    typedef logic [REG_W-1:0] reg_idx_t;

    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic id_ex_en;
        logic ex_mem_en;
        logic mem_wb_en;
        logic if_id_flush;
        logic id_ex_flush;
        logic ex_mem_flush;
        logic mem_wb_flush;
    } ctl_t;

    // Canned control words; field order is pc, four enables, four flushes.
    localparam ctl_t CTL_RUN    = 9'b1_1111_0000;
    localparam ctl_t CTL_RESET  = 9'b0_0000_1111;
    localparam ctl_t CTL_FREEZE = 9'b0_0001_0001;
    localparam ctl_t CTL_IDLE   = 9'b0_0000_0000;

endpackage

// File: rtl/pipeline_hazard_ctrl_if.sv
// Pipeline-side status and stage-control bundle; the pipeline is master,
// the hazard sequencer is slave.
interface pipeline_hazard_ctrl_if;
    import pipe_ctrl_pkg::*;

    reg_idx_t ID_rs_reg;
    reg_idx_t ID_rt_reg;
    logic     ID_uses_rs;
    logic     ID_uses_rt;
    logic     ID_Hlt;
    logic     ID_br_mispredict;
    logic     EX_MemRead;
    reg_idx_t EX_rd_reg;
    logic     MEM_mem_access;
    logic     dmem_ready;
    logic     imem_ready;
    logic     WB_Hlt;

    logic PC_en;
    logic IF_ID_en;
    logic ID_EX_en;
    logic EX_MEM_en;
    logic MEM_WB_en;
    logic IF_ID_flush;
    logic ID_EX_flush;
    logic EX_MEM_flush;
    logic MEM_WB_flush;

    modport master (
        output ID_rs_reg, ID_rt_reg, ID_uses_rs, ID_uses_rt, ID_Hlt,
               ID_br_mispredict, EX_MemRead, EX_rd_reg, MEM_mem_access,
               dmem_ready, imem_ready, WB_Hlt,
        input  PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en,
               IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush
    );

    modport slave (
        input  ID_rs_reg, ID_rt_reg, ID_uses_rs, ID_uses_rt, ID_Hlt,
               ID_br_mispredict, EX_MemRead, EX_rd_reg, MEM_mem_access,
               dmem_ready, imem_ready, WB_Hlt,
        output PC_en, IF_ID_en, ID_EX_en, EX_MEM_en, MEM_WB_en,
               IF_ID_flush, ID_EX_flush, EX_MEM_flush, MEM_WB_flush
    );

endinterface

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use comparator: a load in EX whose destination feeds the instruction
// in ID. r0 is hardwired, so it never creates a dependency.
module hazard_detect
    import pipe_ctrl_pkg::*;
(
    input  reg_idx_t ID_rs_reg,
    input  reg_idx_t ID_rt_reg,
    input  logic     ID_uses_rs,
    input  logic     ID_uses_rt,
    input  logic     EX_MemRead,
    input  reg_idx_t EX_rd_reg,
    output logic     load_use
);

    logic rs_hit;
    logic rt_hit;

    assign rs_hit   = ID_uses_rs && (ID_rs_reg == EX_rd_reg);
    assign rt_hit   = ID_uses_rt && (ID_rt_reg == EX_rd_reg);
    assign load_use = EX_MemRead && (EX_rd_reg != REG_ZERO) && (rs_hit || rt_hit);

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central 5-stage pipeline sequencer: stage enables/flushes, PC write,
// DMEM wait/timeout tracking, HLT drain and a saturating stall counter.
module pipeline_hazard_ctrl
    import pipe_ctrl_pkg::*;
#(
    parameter int          CNT_W        = 16,
    parameter int unsigned DMEM_TIMEOUT = 255
) (
    input  logic                 clk,
    input  logic                 rst,
    pipeline_hazard_ctrl_if.slave pif,
    output logic                 halted,
    output logic                 dmem_err,
    output logic [CNT_W-1:0]     stall_cycles
);

    localparam logic [15:0]      WAIT_LIMIT = 16'(DMEM_TIMEOUT);
    localparam logic [15:0]      WAIT_ONE   = 16'd1;
    localparam logic [CNT_W-1:0] CNT_ONE    = CNT_W'(1);
    localparam logic [CNT_W-1:0] CNT_MAX    = {CNT_W{1'b1}};

    logic [1:0]  state;
    logic [1:0]  state_nxt;
    logic [15:0] wait_cnt;
    logic        load_use;
    logic        dmem_stall;
    logic        stall_count_en;
    ctl_t        ctl;

    hazard_detect u_hazard_detect (
        .ID_rs_reg  (pif.ID_rs_reg),
        .ID_rt_reg  (pif.ID_rt_reg),
        .ID_uses_rs (pif.ID_uses_rs),
        .ID_uses_rt (pif.ID_uses_rt),
        .EX_MemRead (pif.EX_MemRead),
        .EX_rd_reg  (pif.EX_rd_reg),
        .load_use   (load_use)
    );

    assign dmem_stall = pif.MEM_mem_access && !pif.dmem_ready;

    always_comb begin
        ctl       = CTL_RUN;
        state_nxt = state;
        if (rst) begin
            ctl = CTL_RESET;
        end else begin
            case (state)
                ST_RUN: begin
                    if (dmem_stall) begin
                        ctl       = CTL_FREEZE;
                        state_nxt = ST_DWAIT;
                    end else if (load_use) begin
                        // One bubble into EX; a pending mispredict is seen again next cycle.
                        ctl.pc_en       = 1'b0;
                        ctl.if_id_en    = 1'b0;
                        ctl.id_ex_flush = 1'b1;
                    end else if (pif.ID_Hlt) begin
                        ctl.pc_en       = 1'b0;
                        ctl.if_id_flush = 1'b1;
                        state_nxt       = ST_DRAIN;
                    end else begin
                        if (pif.ID_br_mispredict) begin
                            ctl.if_id_flush = 1'b1;
                        end
                        if (!pif.imem_ready) begin
                            ctl.pc_en       = 1'b0;
                            ctl.if_id_flush = 1'b1;
                        end
                    end
                end
                ST_DWAIT: begin
                    if (!pif.dmem_ready) begin
                        ctl = CTL_FREEZE;
                    end else begin
                        state_nxt = ST_RUN;
                    end
                end
                ST_DRAIN: begin
                    if (dmem_stall) begin
                        ctl = CTL_FREEZE;
                    end else begin
                        ctl.pc_en       = 1'b0;
                        ctl.if_id_flush = 1'b1;
                    end
                    if (pif.WB_Hlt) begin
                        state_nxt = ST_HALTED;
                    end
                end
                default: begin
                    ctl = CTL_IDLE;
                end
            endcase
        end
    end

    assign stall_count_en = !ctl.pc_en && ((state == ST_RUN) || (state == ST_DWAIT));

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= ST_RUN;
            wait_cnt     <= '0;
            dmem_err     <= 1'b0;
            stall_cycles <= '0;
        end else begin
            state <= state_nxt;
            // wait_cnt tracks consecutive unanswered DWAIT cycles; it parks at the limit.
            if ((state == ST_DWAIT) && !pif.dmem_ready) begin
                if (wait_cnt != WAIT_LIMIT) begin
                    wait_cnt <= wait_cnt + WAIT_ONE;
                end
                if (wait_cnt >= (WAIT_LIMIT - WAIT_ONE)) begin
                    dmem_err <= 1'b1;
                end
            end else begin
                wait_cnt <= '0;
            end
            if (stall_count_en && (stall_cycles != CNT_MAX)) begin
                stall_cycles <= stall_cycles + CNT_ONE;
            end
        end
    end

    assign halted = (state == ST_HALTED);

    assign pif.PC_en        = ctl.pc_en;
    assign pif.IF_ID_en     = ctl.if_id_en;
    assign pif.ID_EX_en     = ctl.id_ex_en;
    assign pif.EX_MEM_en    = ctl.ex_mem_en;
    assign pif.MEM_WB_en    = ctl.mem_wb_en;
    assign pif.IF_ID_flush  = ctl.if_id_flush;
    assign pif.ID_EX_flush  = ctl.id_ex_flush;
    assign pif.EX_MEM_flush = ctl.ex_mem_flush;
    assign pif.MEM_WB_flush = ctl.mem_wb_flush;

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Self-checking bench for pipeline_hazard_ctrl: directed scenarios plus a
// randomized run against a rule-level reference model.
module tb_pipeline_hazard_ctrl;

    localparam int CNT_W   = 4;
    localparam int TO      = 4;
    localparam int CNT_SAT = 15;

    // {pc, if_id_en, id_ex_en, ex_mem_en, mem_wb_en, if_id_fl, id_ex_fl, ex_mem_fl, mem_wb_fl}
    localparam logic [8:0] RUN_C = 9'b1_1111_0000;
    localparam logic [8:0] RST_C = 9'b0_0000_1111;
    localparam logic [8:0] FRZ_C = 9'b0_0001_0001;
    localparam logic [8:0] LU_C  = 9'b0_0111_0100;
    localparam logic [8:0] IFF_C = 9'b0_1111_1000;
    localparam logic [8:0] MIS_C = 9'b1_1111_1000;
    localparam logic [8:0] HLT_C = 9'b0_0000_0000;

    logic             clk = 1'b0;
    logic             rst;
    logic             halted;
    logic             dmem_err;
    logic [CNT_W-1:0] stall_cycles;
    logic [8:0]       ctl_obs;

    int vectors     = 0;
    int miscompares = 0;

    // reference model state
    bit m_waiting, m_draining, m_halted, m_err;
    int m_wait, m_stalls;

    pipeline_hazard_ctrl_if pif ();

    pipeline_hazard_ctrl #(.CNT_W(CNT_W), .DMEM_TIMEOUT(TO)) dut (
        .clk          (clk),
        .rst          (rst),
        .pif          (pif),
        .halted       (halted),
        .dmem_err     (dmem_err),
        .stall_cycles (stall_cycles)
    );

    always #5 clk = ~clk;

    assign ctl_obs = {pif.PC_en, pif.IF_ID_en, pif.ID_EX_en, pif.EX_MEM_en, pif.MEM_WB_en,
                      pif.IF_ID_flush, pif.ID_EX_flush, pif.EX_MEM_flush, pif.MEM_WB_flush};

    function automatic bit model_load_use();
        int rd = int'(pif.EX_rd_reg);
        return pif.EX_MemRead && (rd != 0) &&
               ((pif.ID_uses_rs && int'(pif.ID_rs_reg) == rd) ||
                (pif.ID_uses_rt && int'(pif.ID_rt_reg) == rd));
    endfunction

    function automatic logic [8:0] model_ctl();
        logic [8:0] c;
        if (rst) return RST_C;
        if (m_halted) return HLT_C;
        if (m_waiting) return pif.dmem_ready ? RUN_C : FRZ_C;
        if (pif.MEM_mem_access && !pif.dmem_ready) return FRZ_C;
        if (m_draining) return IFF_C;
        if (model_load_use()) return LU_C;
        if (pif.ID_Hlt) return IFF_C;
        c = RUN_C;
        if (pif.ID_br_mispredict) c[3] = 1'b1;
        if (!pif.imem_ready) begin
            c[8] = 1'b0;
            c[3] = 1'b1;
        end
        return c;
    endfunction

    task automatic model_update();
        logic [8:0] c;
        c = model_ctl();
        if (rst) begin
            m_waiting = 0; m_draining = 0; m_halted = 0; m_err = 0;
            m_wait = 0; m_stalls = 0;
            return;
        end
        if (!m_halted && !m_draining && !c[8]) m_stalls = (m_stalls >= CNT_SAT) ? CNT_SAT : m_stalls + 1;
        if (m_waiting) begin
            if (pif.dmem_ready) begin
                m_waiting = 0;
                m_wait    = 0;
            end else begin
                m_wait++;
                if (m_wait >= TO) m_err = 1;
            end
        end else if (m_draining) begin
            if (pif.WB_Hlt) begin
                m_draining = 0;
                m_halted   = 1;
            end
        end else if (!m_halted) begin
            if (pif.MEM_mem_access && !pif.dmem_ready) m_waiting = 1;
            else if (!model_load_use() && pif.ID_Hlt) m_draining = 1;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_update();
        #1;
    endtask

    task automatic set_idle();
        pif.ID_rs_reg = '0; pif.ID_rt_reg = '0; pif.ID_uses_rs = 0; pif.ID_uses_rt = 0;
        pif.ID_Hlt = 0; pif.ID_br_mispredict = 0; pif.EX_MemRead = 0; pif.EX_rd_reg = '0;
        pif.MEM_mem_access = 0; pif.dmem_ready = 1; pif.imem_ready = 1; pif.WB_Hlt = 0;
    endtask

    task automatic do_reset();
        set_idle();
        rst = 1;
        tick();
        rst = 0;
    endtask

    task automatic test_reset();
        set_idle();
        rst = 1;
        @(negedge clk);
        vectors++;
        if (ctl_obs !== RST_C) begin miscompares++; $display("FAIL reset_ctl: got %b want %b", ctl_obs, RST_C); end
        tick();
        rst = 0;
        @(negedge clk);
        vectors++;
        if (ctl_obs !== RUN_C) begin miscompares++; $display("FAIL reset_run_ctl: got %b want %b", ctl_obs, RUN_C); end
        vectors++;
        if ({halted, dmem_err, stall_cycles} !== {2'b00, 4'd0}) begin
            miscompares++; $display("FAIL reset_regs: halted=%b err=%b stalls=%0d want 0/0/0", halted, dmem_err, stall_cycles);
        end
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        pif.EX_MemRead = 1; pif.EX_rd_reg = 4'd5; pif.ID_rs_reg = 4'd5; pif.ID_uses_rs = 1;
        @(negedge clk);
        vectors++;
        if (ctl_obs !== LU_C) begin miscompares++; $display("FAIL load_use_rs: got %b want %b", ctl_obs, LU_C); end
        tick();
        pif.EX_MemRead = 0;   // the load has moved on, bubble is in EX
        @(negedge clk);
        vectors++;
        if (ctl_obs !== RUN_C) begin miscompares++; $display("FAIL load_use_single_bubble: got %b want %b", ctl_obs, RUN_C); end
        tick();
        pif.EX_MemRead = 1; pif.EX_rd_reg = 4'd0; pif.ID_rs_reg = 4'd0;
        @(negedge clk);
        vectors++;
        if (ctl_obs !== RUN_C) begin miscompares++; $display("FAIL load_use_r0: got %b want %b", ctl_obs, RUN_C); end
        tick();
        pif.ID_uses_rs = 0; pif.ID_uses_rt = 1; pif.ID_rt_reg = 4'd9; pif.EX_rd_reg = 4'd9; pif.ID_rs_reg = 4'd9;
        @(negedge clk);
        vectors++;
        if (ctl_obs !== LU_C) begin miscompares++; $display("FAIL load_use_rt: got %b want %b", ctl_obs, LU_C); end
        tick();
        pif.ID_uses_rt = 0;
        @(negedge clk);
        vectors++;
        if (ctl_obs !== RUN_C) begin miscompares++; $display("FAIL load_use_unused_src: got %b want %b", ctl_obs, RUN_C); end
        vectors++;
        if (stall_cycles !== 4'd2) begin miscompares++; $display("FAIL load_use_stall_count: got %0d want 2", stall_cycles); end
        tick();
    endtask

    task automatic test_dmem_wait();
        do_reset();
        pif.MEM_mem_access = 1; pif.dmem_ready = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if (ctl_obs !== FRZ_C) begin miscompares++; $display("FAIL dmem_wait_freeze[%0d]: got %b want %b", c, ctl_obs, FRZ_C); end
            tick();
        end
        pif.dmem_ready = 1;
        @(negedge clk);
        vectors++;
        if (ctl_obs !== RUN_C) begin miscompares++; $display("FAIL dmem_wait_ready: got %b want %b", ctl_obs, RUN_C); end
        tick();
        pif.MEM_mem_access = 0; pif.dmem_ready = 0;
        @(negedge clk);
        vectors++;
        if (ctl_obs !== RUN_C) begin miscompares++; $display("FAIL dmem_wait_back_to_run: got %b want %b", ctl_obs, RUN_C); end
        vectors++;
        if (stall_cycles !== 4'd3) begin miscompares++; $display("FAIL dmem_wait_stalls: got %0d want 3", stall_cycles); end
        tick();
    endtask

    task automatic test_timeout();
        do_reset();
        pif.MEM_mem_access = 1; pif.dmem_ready = 0;
        // cycle 0 is the RUN cycle that sees the stall; cycles 1..4 are DWAIT
        for (int c = 0; c < 20; c++) begin
            @(negedge clk);
            vectors++;
            if (ctl_obs !== FRZ_C) begin miscompares++; $display("FAIL timeout_freeze[%0d]: got %b want %b", c, ctl_obs, FRZ_C); end
            vectors++;
            if (dmem_err !== (c >= TO + 1)) begin miscompares++; $display("FAIL timeout_err[%0d]: got %b want %b", c, dmem_err, (c >= TO + 1)); end
            vectors++;
            if (int'(stall_cycles) != ((c > CNT_SAT) ? CNT_SAT : c)) begin
                miscompares++; $display("FAIL timeout_stalls[%0d]: got %0d want %0d", c, stall_cycles, (c > CNT_SAT) ? CNT_SAT : c);
            end
            tick();
        end
        pif.dmem_ready = 1;
        @(negedge clk);
        vectors++;
        if (ctl_obs !== RUN_C) begin miscompares++; $display("FAIL timeout_ready: got %b want %b", ctl_obs, RUN_C); end
        tick();
        pif.MEM_mem_access = 0;
        @(negedge clk);
        vectors++;
        if (dmem_err !== 1'b1) begin miscompares++; $display("FAIL timeout_sticky: got %b want 1", dmem_err); end
        do_reset();
        @(negedge clk);
        vectors++;
        if (dmem_err !== 1'b0) begin miscompares++; $display("FAIL timeout_rst_clear: got %b want 0", dmem_err); end
        tick();
    endtask

    task automatic test_simultaneous();
        do_reset();
        pif.ID_br_mispredict = 1; pif.imem_ready = 0;
        @(negedge clk);
        vectors++;
        if (ctl_obs !== IFF_C) begin miscompares++; $display("FAIL mispredict_imem: got %b want %b", ctl_obs, IFF_C); end
        tick();
        pif.imem_ready = 1;
        @(negedge clk);
        vectors++;
        if (ctl_obs !== MIS_C) begin miscompares++; $display("FAIL mispredict_only: got %b want %b", ctl_obs, MIS_C); end
        tick();
        pif.ID_br_mispredict = 0; pif.imem_ready = 0;
        @(negedge clk);
        vectors++;
        if (ctl_obs !== IFF_C) begin miscompares++; $display("FAIL imem_only: got %b want %b", ctl_obs, IFF_C); end
        tick();
        pif.ID_br_mispredict = 1;
        pif.EX_MemRead = 1; pif.EX_rd_reg = 4'd3; pif.ID_rt_reg = 4'd3; pif.ID_uses_rt = 1;
        @(negedge clk);
        vectors++;
        if (ctl_obs !== LU_C) begin miscompares++; $display("FAIL load_use_beats_mispredict: got %b want %b", ctl_obs, LU_C); end
        tick();
    endtask

    task automatic test_halt();
        do_reset();
        pif.ID_Hlt = 1;
        @(negedge clk);
        vectors++;
        if (ctl_obs !== IFF_C) begin miscompares++; $display("FAIL halt_id_cycle: got %b want %b", ctl_obs, IFF_C); end
        tick();
        pif.ID_Hlt = 0;
        for (int c = 1; c <= 3; c++) begin
            pif.WB_Hlt = (c == 3);
            @(negedge clk);
            vectors++;
            if (ctl_obs !== IFF_C) begin miscompares++; $display("FAIL halt_drain[%0d]: got %b want %b", c, ctl_obs, IFF_C); end
            vectors++;
            if (halted !== 1'b0) begin miscompares++; $display("FAIL halt_early[%0d]: got %b want 0", c, halted); end
            tick();
        end
        pif.WB_Hlt = 0; pif.MEM_mem_access = 1; pif.dmem_ready = 0; pif.imem_ready = 0;
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            vectors++;
            if ({halted, ctl_obs} !== {1'b1, HLT_C}) begin
                miscompares++; $display("FAIL halted_state[%0d]: halted=%b ctl=%b want 1/%b", c, halted, ctl_obs, HLT_C);
            end
            tick();
        end
        @(negedge clk);
        vectors++;
        if (stall_cycles !== 4'd1) begin miscompares++; $display("FAIL halt_stall_count: got %0d want 1", stall_cycles); end
        tick();
    endtask

    task automatic test_reset_mid_dwait();
        do_reset();
        pif.MEM_mem_access = 1; pif.dmem_ready = 0;
        tick();
        tick();
        rst = 1;
        @(negedge clk);
        vectors++;
        if (ctl_obs !== RST_C) begin miscompares++; $display("FAIL rst_mid_dwait_ctl: got %b want %b", ctl_obs, RST_C); end
        tick();
        rst = 0; pif.MEM_mem_access = 0;
        @(negedge clk);
        vectors++;
        if ({ctl_obs, halted, dmem_err, stall_cycles} !== {RUN_C, 2'b00, 4'd0}) begin
            miscompares++;
            $display("FAIL rst_mid_dwait_after: ctl=%b halted=%b err=%b stalls=%0d want %b/0/0/0", ctl_obs, halted, dmem_err, stall_cycles, RUN_C);
        end
        tick();
    endtask

    task automatic test_random();
        logic [8:0] exp_ctl;
        do_reset();
        for (int n = 0; n < 1500; n++) begin
            rst                  = ($urandom_range(0, 59) == 0);
            pif.ID_rs_reg        = 4'($urandom_range(0, 3));
            pif.ID_rt_reg        = 4'($urandom_range(0, 3));
            pif.ID_uses_rs       = 1'($urandom_range(0, 1));
            pif.ID_uses_rt       = 1'($urandom_range(0, 1));
            pif.ID_Hlt           = ($urandom_range(0, 29) == 0);
            pif.ID_br_mispredict = ($urandom_range(0, 4) == 0);
            pif.EX_MemRead       = ($urandom_range(0, 2) == 0);
            pif.EX_rd_reg        = 4'($urandom_range(0, 3));
            pif.MEM_mem_access   = ($urandom_range(0, 2) == 0);
            pif.dmem_ready       = ($urandom_range(0, 9) < 6);
            pif.imem_ready       = ($urandom_range(0, 9) < 8);
            pif.WB_Hlt           = ($urandom_range(0, 4) == 0);
            @(negedge clk);
            exp_ctl = model_ctl();
            vectors++;
            if (ctl_obs !== exp_ctl) begin miscompares++; $display("FAIL rand_ctl[%0d]: got %b want %b", n, ctl_obs, exp_ctl); end
            vectors++;
            if ({halted, dmem_err} !== {m_halted, m_err}) begin
                miscompares++; $display("FAIL rand_flags[%0d]: halted=%b err=%b want %b/%b", n, halted, dmem_err, m_halted, m_err);
            end
            vectors++;
            if (int'(stall_cycles) != m_stalls) begin
                miscompares++; $display("FAIL rand_stalls[%0d]: got %0d want %0d", n, stall_cycles, m_stalls);
            end
            tick();
        end
        rst = 0;
    endtask

    initial begin
        set_idle();
        rst = 1;
        m_waiting = 0; m_draining = 0; m_halted = 0; m_err = 0; m_wait = 0; m_stalls = 0;
        tick();
        test_reset();
        test_load_use();
        test_dmem_wait();
        test_timeout();
        test_simultaneous();
        test_halt();
        test_reset_mid_dwait();
        test_random();
        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
